mul_share_arbiter: RTL and testbench

Shares one 8x8 unsigned multiplier (`int_mul_8`-class: `num1`, `num2` in, 16-bit `result` out, fixed latency) among several requesters.
- Requesters post operand pairs.
- The block arbitrates among them, drives the multiplier operands, waits the multiplier latency, and returns the 16-bit product tagged to the winning requester.
- It sits in `top` between user logic and the single multiplier instance.

---
 rtl/mul_share_arbiter.sv | 119 +++++++++++
 tb/tb_mul_share_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// Shares one fixed-latency 8x8 multiplier among NUM_REQ requesters.
// Define MUL_SHARE_FIXED_PRIO_EN for fixed priority (lowest index wins); round-robin by default.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   op_a,
  input  logic [8*NUM_REQ-1:0]   op_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   busy,
  output logic [7:0]             mul_num1,
  output logic [7:0]             mul_num2,
  input  logic [15:0]            mul_result,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] sel;

`ifdef MUL_SHARE_FIXED_PRIO_EN
  function automatic logic [IDX_W-1:0] prio_pick(input logic [NUM_REQ-1:0] r);
    logic [IDX_W-1:0] pick;
    // NOTE: pick gets a default before the loop, so no path leaves it unassigned (no latch).
    pick = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r[IDX_W'(i)]) pick = IDX_W'(i);
    end
    return pick;
  endfunction

  assign sel = prio_pick(req);
`else
  logic [IDX_W-1:0] ptr;

  // Walk offsets from the far end toward ptr so the nearest requester at/after ptr wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [IDX_W-1:0]   p);
    logic [IDX_W-1:0] pick;
    int               k;
    pick = p;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(p) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (r[IDX_W'(k)]) pick = IDX_W'(k);
    end
    return pick;
  endfunction

  assign sel = rr_pick(req, ptr);
`endif

  // NOTE: all state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: every register is reset, because each output must read 0 and in-flight work is dropped.
      state     <= IDLE;
      cnt       <= '0;
      win       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      busy      <= 1'b0;
      mul_num1  <= '0;
      mul_num2  <= '0;
      rsp_data  <= '0;
`ifndef MUL_SHARE_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            win      <= sel;
            mul_num1 <= op_a[{sel, 3'b000} +: 8];
            mul_num2 <= op_b[{sel, 3'b000} +: 8];
            gnt      <= ONE << sel;
            busy     <= 1'b1;
            state    <= ISSUE;
`ifndef MUL_SHARE_FIXED_PRIO_EN
            ptr      <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`endif
          end
        end
        ISSUE: begin
          cnt   <= CNT_W'(MUL_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data  <= mul_result;
            rsp_valid <= ONE << win;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: a transaction-level model predicts grants,
// and a scoreboard queue holds expected responses until the DUT delivers them.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int L       = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] op_a, op_b;
  logic [3:0]  gnt, rsp_valid;
  logic        busy;
  logic [7:0]  mul_num1, mul_num2;
  logic [15:0] mul_result, rsp_data;
  logic [15:0] mp1, mp2;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .busy(busy), .mul_num1(mul_num1), .mul_num2(mul_num2),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  // Two-stage multiplier, matching L = 2.
  always @(posedge clk) begin
    mp1 <= {8'd0, mul_num1} * {8'd0, mul_num2};
    mp2 <= mp1;
  end
  assign mul_result = mp2;

  typedef struct { int idx; logic [15:0] prod; int due; } exp_t;
  typedef struct { logic [3:0] v; logic [15:0] data; } rsp_t;

  exp_t sb[$];
  rsp_t rsp_log[$];
  int   gnt_log[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int p);
`ifdef MUL_SHARE_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (r[i]) return i;
`else
    for (int i = 0; i < NUM_REQ; i++) if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
`endif
    return -1;
  endfunction

  function automatic int log_g(input int i);
    return (i < gnt_log.size()) ? gnt_log[i] : -1;
  endfunction

  function automatic int log_d(input int i);
    return (i < rsp_log.size()) ? int'(rsp_log[i].data) : -1;
  endfunction

  function automatic int log_v(input int i);
    return (i < rsp_log.size()) ? int'(rsp_log[i].v) : -1;
  endfunction

  // Monitor and model: one pass per rising edge, checks taken 1 ns after the edge.
  logic [3:0]  req_s, exp_gnt;
  logic [31:0] a_s, b_s;
  logic        rst_s;
  int          cyc = 0, m_ptr = 0, m_left = 0, w;
  bit          m_idle = 1'b1;
  exp_t        e;

  initial begin
    forever begin
      @(posedge clk);
      req_s = req; a_s = op_a; b_s = op_b; rst_s = reset;
      #1;
      cyc++;
      exp_gnt = '0;
      if (rst_s) begin
        sb.delete();
        m_ptr = 0; m_idle = 1'b1; m_left = 0;
        check("rst_num1", mul_num1, 0);
        check("rst_num2", mul_num2, 0);
        check("rst_rsp_data", rsp_data, 0);
      end else if (m_idle) begin
        if (req_s != '0) begin
          w       = model_pick(req_s, m_ptr);
          m_ptr   = (w + 1) % NUM_REQ;
          m_idle  = 1'b0;
          m_left  = L + 2;
          exp_gnt = 4'(1 << w);
          e.idx   = w;
          e.prod  = {8'd0, a_s[w*8 +: 8]} * {8'd0, b_s[w*8 +: 8]};
          e.due   = cyc + L + 1;
          sb.push_back(e);
          gnt_log.push_back(w);
          check("num1", mul_num1, a_s[w*8 +: 8]);
          check("num2", mul_num2, b_s[w*8 +: 8]);
        end
      end else begin
        m_left--;
        if (m_left == 0) m_idle = 1'b1;
      end
      check("gnt", gnt, exp_gnt);
      check("busy", busy, m_idle ? 0 : 1);
      if (rsp_valid != '0) rsp_log.push_back('{rsp_valid, rsp_data});
      if (sb.size() > 0 && sb[0].due == cyc) begin
        check("rsp_valid", rsp_valid, 1 << sb[0].idx);
        check("rsp_data", rsp_data, sb[0].prod);
        void'(sb.pop_front());
      end else begin
        check("rsp_valid_idle", rsp_valid, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    op_a[i*8 +: 8] = a;
    op_b[i*8 +: 8] = b;
  endtask

  // Hold req until every requester has been served; drop on gnt or on response.
  task automatic serve(input bit on_rsp, input int max_cyc);
    int n = 0;
    while (req != '0 && n < max_cyc) begin
      tick(1);
      n++;
      if (on_rsp) req = req & ~rsp_valid;
      else        req = req & ~gnt;
    end
    check("serve_timeout", (n < max_cyc) ? 1 : 0, 1);
    req = '0;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req = '0; op_a = '0; op_b = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Single request from requester 1
    clear_logs();
    set_ops(1, 8'd12, 8'd13);
    req = 4'b0010; tick(1); req = '0;
    tick(L + 4);
    check("single_gnt_cnt", gnt_log.size(), 1);
    check("single_gnt", log_g(0), 1);
    check("single_rsp_v", log_v(0), 4'b0010);
    check("single_rsp_d", log_d(0), 156);

    // Operand extremes
    clear_logs();
    set_ops(0, 8'd255, 8'd255);
    req = 4'b0001; tick(1); req = '0;
    tick(L + 4);
    set_ops(3, 8'd0, 8'd200);
    req = 4'b1000; tick(1); req = '0;
    tick(L + 4);
    check("max_rsp_d", log_d(0), 65025);
    check("zero_rsp_d", log_d(1), 0);
    check("zero_rsp_v", log_v(1), 4'b1000);

    // All four requesting, each drops after its response
    clear_logs();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 8'(10 + i), 8'(20 + 3 * i));
    req = 4'b1111;
    serve(1'b1, 200);
    tick(2);
    check("rr_cnt", gnt_log.size(), 4);
    for (int i = 0; i < NUM_REQ; i++) check("rr_order", log_g(i), i);

    // Wrap-around after requester 3
    clear_logs();
    req = 4'b1000; tick(1); req = '0;
    tick(L + 4);
    req = 4'b1001;
    serve(1'b0, 100);
    tick(L + 4);
    check("wrap_g1", log_g(1), 0);
    check("wrap_g2", log_g(2), 3);

    // Reset during WAIT, then pointer must be back at 0
    clear_logs();
    req = 4'b0010; tick(1); req = '0;
    tick(L + 4);
    set_ops(2, 8'd7, 8'd9);
    req = 4'b0100; tick(1); req = '0;
    tick(1);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_gnt", gnt, 0);
    tick(L + 4);
    check("rst_no_rsp", rsp_log.size(), 1);
    set_ops(3, 8'd17, 8'd3);
    req = 4'b1100;
    serve(1'b0, 100);
    tick(L + 4);
    check("rst_next_g", log_g(2), 2);
    check("rst_next_g2", log_g(3), 3);
    check("rst_next_d", log_d(1), 63);

    // Late drop: one extra cycle is harmless, holding to IDLE gives a second transaction
    clear_logs();
    set_ops(0, 8'd3, 8'd4);
    req = 4'b0001; tick(1); tick(2); req = '0;
    tick(L + 4);
    check("late_one", gnt_log.size(), 1);
    set_ops(1, 8'd5, 8'd6);
    req = 4'b0010; tick(L + 4); req = '0;
    tick(L + 4);
    check("late_two", gnt_log.size(), 3);
    check("late_g2", log_g(2), 1);
    check("late_d2", log_d(2), 30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
